load_store_unit: RTL and testbench

Initiator side of the data bus: accepts one load or store at a time from the execute stage and runs the bus transaction to the SRAM responder. It drives address, mode, width and sign-extension controls, and drives write data onto the shared tri-state data lines. For loads it captures the returned word and returns it to the pipeline. It stalls the pipeline while a load is in flight, and rejects misaligned or unmapped accesses without starting any bus cycle.

---
 rtl/load_store_unit.sv | 151 +++++++++++++++
 tb/tb_load_store_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: bus initiator that runs one load or store at a time toward the SRAM responder.
// Misaligned, illegal-width and unmapped requests are rejected in IDLE without starting a bus cycle.
module load_store_unit #(
  parameter logic [31:0] MAP_BASE = 32'h2000,
  parameter logic [31:0] MAP_END  = 32'h2FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_width,
  input  logic        req_signed,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        fault_misaligned,
  output logic        fault_unmapped,
  output logic        stall_lw,
  inout  wire  [31:0] data_bus_data,
  output logic [31:0] data_bus_addr,
  output logic [1:0]  data_bus_mode,
  output logic [1:0]  data_bus_reqw,
  output logic        data_bus_reqs
);

  typedef enum logic [1:0] {IDLE, READ_ADDR, READ_DATA, WRITE} state_t;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b10;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  mode_q, mode_d;
  logic [1:0]  reqw_q, reqw_d;
  logic        reqs_q, reqs_d;
  logic        resp_valid_q, resp_valid_d;
  logic        fault_mis_q, fault_mis_d;
  logic        fault_unm_q, fault_unm_d;
  logic        accept, misaligned, unmapped, req_ok;

  always_comb begin
    case (req_width)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  assign unmapped = (req_addr < MAP_BASE) || (req_addr > MAP_END);
  assign req_ok   = !misaligned && !unmapped;
  assign accept   = req_valid && (state_q == IDLE);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    reqw_d       = reqw_q;
    reqs_d       = reqs_q;
    mode_d       = MODE_IDLE;
    resp_valid_d = 1'b0;
    fault_mis_d  = 1'b0;
    fault_unm_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Rejected requests leave the bus address/width/sign registers untouched
        if (accept) begin
          if (misaligned) begin
            fault_mis_d = 1'b1;
          end else if (unmapped) begin
            fault_unm_d = 1'b1;
          end else begin
            addr_d  = req_addr;
            wdata_d = req_wdata;
            reqw_d  = req_width;
            reqs_d  = req_signed;
            if (req_write) begin
              state_d = WRITE;
              mode_d  = MODE_WRITE;
            end else begin
              state_d = READ_ADDR;
              mode_d  = MODE_READ;
            end
          end
        end
      end
      READ_ADDR: begin
        state_d = READ_DATA;
        mode_d  = MODE_READ;
      end
      READ_DATA: begin
        state_d      = IDLE;
        rdata_d      = data_bus_data;
        resp_valid_d = 1'b1;
      end
      WRITE: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      mode_q       <= MODE_IDLE;
      reqw_q       <= '0;
      reqs_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      fault_mis_q  <= 1'b0;
      fault_unm_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      mode_q       <= mode_d;
      reqw_q       <= reqw_d;
      reqs_q       <= reqs_d;
      resp_valid_q <= resp_valid_d;
      fault_mis_q  <= fault_mis_d;
      fault_unm_q  <= fault_unm_d;
    end
  end

  // Drive enable comes from the registered state so it can never overlap the responder's read drive
  assign data_bus_data = (state_q == WRITE) ? wdata_q : 32'hzzzz_zzzz;

  assign req_ready        = (state_q == IDLE);
  assign stall_lw         = (state_q == READ_ADDR) || (state_q == READ_DATA) ||
                            (accept && !req_write && req_ok);
  assign resp_valid       = resp_valid_q;
  assign resp_rdata       = rdata_q;
  assign fault_misaligned = fault_mis_q;
  assign fault_unmapped   = fault_unm_q;
  assign data_bus_addr    = addr_q;
  assign data_bus_mode    = mode_q;
  assign data_bus_reqw    = reqw_q;
  assign data_bus_reqs    = reqs_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: SRAM responder on the shared bus plus a byte-array reference model
// that predicts every load result, fault and bus cycle from the access rules.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_width;
  logic        req_ready, resp_valid, fault_misaligned, fault_unmapped, stall_lw;
  logic [31:0] resp_rdata, data_bus_addr;
  logic [1:0]  data_bus_mode, data_bus_reqw;
  logic        data_bus_reqs;
  wire  [31:0] data_bus_data;

  int checks = 0;
  int errors = 0;

  logic [7:0]  sram [4096];
  logic [7:0]  mdl  [4096];
  logic        sram_init;
  logic [31:0] resp_word;
  logic [11:0] ro;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_width(req_width), .req_signed(req_signed),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .fault_misaligned(fault_misaligned), .fault_unmapped(fault_unmapped), .stall_lw(stall_lw),
    .data_bus_data(data_bus_data), .data_bus_addr(data_bus_addr), .data_bus_mode(data_bus_mode),
    .data_bus_reqw(data_bus_reqw), .data_bus_reqs(data_bus_reqs)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37) ^ 8'h5A);
  endfunction

  // SRAM responder: width/sign handling on reads, drive enable decoded from mode combinationally
  always_comb begin
    ro = data_bus_addr[11:0];
    case (data_bus_reqw)
      2'b00:   resp_word = data_bus_reqs ? {{24{sram[ro][7]}}, sram[ro]} : {24'h0, sram[ro]};
      2'b01:   resp_word = data_bus_reqs ? {{16{sram[ro + 12'd1][7]}}, sram[ro + 12'd1], sram[ro]}
                                         : {16'h0, sram[ro + 12'd1], sram[ro]};
      default: resp_word = {sram[ro + 12'd3], sram[ro + 12'd2], sram[ro + 12'd1], sram[ro]};
    endcase
  end

  assign data_bus_data = (data_bus_mode == 2'b01) ? resp_word : 32'hzzzz_zzzz;

  always @(posedge clk) begin
    if (sram_init) begin
      for (int i = 0; i < 4096; i++) sram[i] <= init_byte(i);
    end else if (data_bus_mode == 2'b10) begin
      sram[ro] <= data_bus_data[7:0];
      if (data_bus_reqw != 2'b00) sram[ro + 12'd1] <= data_bus_data[15:8];
      if (data_bus_reqw == 2'b10) begin
        sram[ro + 12'd2] <= data_bus_data[23:16];
        sram[ro + 12'd3] <= data_bus_data[31:24];
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] wid, input bit sg);
    int sz;
    int off;
    logic [31:0] v;
    sz  = 1 << wid;
    off = int'(a - 32'h2000);
    v   = '0;
    for (int k = 0; k < sz; k++) v = v | (32'(mdl[off + k]) << (8 * k));
    if (sg && sz < 4 && v[8 * sz - 1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] wid);
    int off;
    off = int'(a - 32'h2000);
    for (int k = 0; k < (1 << wid); k++) mdl[off + k] = 8'(wd >> (8 * k));
  endtask

  // Presents one request at the current negedge and follows it to its response;
  // with hold set, req_valid stays high so the next call lands in the response cycle
  task automatic apply_stimulus(input bit w, input logic [31:0] a, input logic [31:0] wd,
                                input logic [1:0] wid, input bit sg, input bit hold);
    int  sz;
    bit  mis, unm;
    logic [31:0] exp_rd;
    sz  = (wid == 2'd3) ? 4 : (1 << wid);
    mis = (wid == 2'd3) || ((a % sz) != 0);
    unm = !mis && ((a < 32'h2000) || (a > 32'h2FFF));
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_width = wid; req_signed = sg;
    #1;
    check_output("ready_at_issue", 32'(req_ready), 32'd1);
    check_output("stall_at_issue", 32'(stall_lw), 32'(!w && !mis && !unm));
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    #1;
    if (mis || unm) begin
      check_output("fault_mis_pulse", 32'(fault_misaligned), 32'(mis));
      check_output("fault_unm_pulse", 32'(fault_unmapped), 32'(unm));
      check_output("fault_mode", 32'(data_bus_mode), 32'd0);
      check_output("fault_resp", 32'(resp_valid), 32'd0);
      check_output("fault_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      #1;
      check_output("fault_mis_end", 32'(fault_misaligned), 32'd0);
      check_output("fault_unm_end", 32'(fault_unmapped), 32'd0);
      check_output("fault_no_resp", 32'(resp_valid), 32'd0);
    end else if (w) begin
      check_output("wr_mode", 32'(data_bus_mode), 32'd2);
      check_output("wr_data", data_bus_data, wd);
      check_output("wr_addr", data_bus_addr, a);
      check_output("wr_reqw", 32'(data_bus_reqw), 32'(wid));
      check_output("wr_ready", 32'(req_ready), 32'd0);
      check_output("wr_stall", 32'(stall_lw), 32'd0);
      check_output("wr_resp_early", 32'(resp_valid), 32'd0);
      model_store(a, wd, wid);
      @(negedge clk);
      #1;
      check_output("wr_resp", 32'(resp_valid), 32'd1);
      check_output("wr_mode_after", 32'(data_bus_mode), 32'd0);
    end else begin
      exp_rd = model_load(a, wid, sg);
      check_output("rd1_mode", 32'(data_bus_mode), 32'd1);
      check_output("rd1_addr", data_bus_addr, a);
      check_output("rd1_reqw", 32'(data_bus_reqw), 32'(wid));
      check_output("rd1_reqs", 32'(data_bus_reqs), 32'(sg));
      check_output("rd1_stall", 32'(stall_lw), 32'd1);
      check_output("rd1_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      #1;
      check_output("rd2_mode", 32'(data_bus_mode), 32'd1);
      check_output("rd2_addr", data_bus_addr, a);
      check_output("rd2_stall", 32'(stall_lw), 32'd1);
      check_output("rd2_resp", 32'(resp_valid), 32'd0);
      @(negedge clk);
      #1;
      check_output("rd_resp", 32'(resp_valid), 32'd1);
      check_output("rd_data", resp_rdata, exp_rd);
      check_output("rd_mode_after", 32'(data_bus_mode), 32'd0);
      check_output("rd_ready_after", 32'(req_ready), 32'd1);
      if (!hold) check_output("rd_stall_after", 32'(stall_lw), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL timeout reached before end of stimulus");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit          w, sg;
    logic [1:0]  wid;
    logic [31:0] a;
    int          r;

    for (int i = 0; i < 4096; i++) mdl[i] = init_byte(i);
    reset = 1'b0; sram_init = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_width = '0; req_signed = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("rst_ready", 32'(req_ready), 32'd1);
    check_output("rst_mode", 32'(data_bus_mode), 32'd0);
    check_output("rst_addr", data_bus_addr, 32'd0);
    check_output("rst_rdata", resp_rdata, 32'd0);
    check_output("rst_resp", 32'(resp_valid), 32'd0);
    check_output("rst_faults", {30'd0, fault_misaligned, fault_unmapped}, 32'd0);
    check_output("rst_stall", 32'(stall_lw), 32'd0);
    reset = 1'b1; sram_init = 1'b0;
    @(negedge clk);

    // Store then load of the same word
    apply_stimulus(1'b1, 32'h2004, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0);
    apply_stimulus(1'b0, 32'h2004, 32'h0, 2'd2, 1'b0, 1'b0);
    check_output("st_ld_word", resp_rdata, 32'hDEADBEEF);

    // Byte sign extension
    apply_stimulus(1'b1, 32'h2803, 32'h0000_0080, 2'd0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 32'h2803, 32'h0, 2'd0, 1'b1, 1'b0);
    check_output("byte_signed", resp_rdata, 32'hFFFFFF80);
    apply_stimulus(1'b0, 32'h2803, 32'h0, 2'd0, 1'b0, 1'b0);
    check_output("byte_unsigned", resp_rdata, 32'h00000080);

    // Misaligned and illegal width, then confirm memory untouched
    apply_stimulus(1'b0, 32'h2002, 32'h0, 2'd2, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h2001, 32'h1234_5678, 2'd1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 32'h2000, 32'h0, 2'd3, 1'b0, 1'b0);
    apply_stimulus(1'b0, 32'h2000, 32'h0, 2'd2, 1'b0, 1'b0);

    // Unmapped on both sides, and the last mapped word
    apply_stimulus(1'b0, 32'h3000, 32'h0, 2'd2, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h1FFC, 32'hCAFE_F00D, 2'd2, 1'b0, 1'b0);
    apply_stimulus(1'b0, 32'h2FFC, 32'h0, 2'd2, 1'b0, 1'b0);

    // Back-to-back with req_valid held high
    apply_stimulus(1'b0, 32'h2100, 32'h0, 2'd2, 1'b0, 1'b1);
    apply_stimulus(1'b1, 32'h2104, 32'hA5A5_1234, 2'd2, 1'b0, 1'b1);
    apply_stimulus(1'b0, 32'h2104, 32'h0, 2'd1, 1'b1, 1'b0);

    // Reset asserted while the load is in READ_DATA
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h2010; req_width = 2'd2; req_signed = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("mid_rst_mode", 32'(data_bus_mode), 32'd0);
    check_output("mid_rst_addr", data_bus_addr, 32'd0);
    check_output("mid_rst_ctl", {29'd0, data_bus_reqw, data_bus_reqs}, 32'd0);
    check_output("mid_rst_rdata", resp_rdata, 32'd0);
    check_output("mid_rst_resp", 32'(resp_valid), 32'd0);
    check_output("mid_rst_stall", 32'(stall_lw), 32'd0);
    check_output("mid_rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    check_output("mid_rst_no_resp", 32'(resp_valid), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_output("post_rst_no_resp", 32'(resp_valid), 32'd0);
    apply_stimulus(1'b0, 32'h2000, 32'h0, 2'd2, 1'b0, 1'b0);

    // Randomized mix of loads, stores and occasional faulting requests
    for (int i = 0; i < 60; i++) begin
      w   = 1'($urandom % 2);
      sg  = 1'($urandom % 2);
      wid = (($urandom % 8) == 0) ? 2'd3 : 2'($urandom % 3);
      a   = 32'h2000 + ($urandom % 4096);
      r   = int'($urandom % 10);
      if (r == 0) a = $urandom;
      else if (r != 1 && wid != 2'd3) a = a & ~((32'd1 << wid) - 32'd1);
      apply_stimulus(w, a, $urandom, wid, sg, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
